// File: rtl/calibration_sequencer.sv
// Sequences speaker calibration: offset capture, settle delay, impulse recording, then run.
// Waits are measured in audio sample strobes, with timeouts that land in ERROR.
module calibration_sequencer #(
    parameter logic [16:0] SETTLE_SAMPLES  = 17'd2400,
    parameter logic [16:0] OFFSET_TIMEOUT  = 17'd48000,
    parameter logic [16:0] IMPULSE_TIMEOUT = 17'd72000
) (
    input  logic       audio_clk,
    input  logic       rst_in,
    input  logic       audio_trigger,
    input  logic       start,
    input  logic       abort,
    input  logic       offset_done,
    input  logic       impulse_done,
    output logic       offset_trigger_out,
    output logic       impulse_trigger_out,
    output logic       conv_enable,
    output logic       spk_mute,
    output logic       busy,
    output logic       error,
    output logic [2:0] state_out
);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        OFS_REQ  = 3'd1,
        OFS_WAIT = 3'd2,
        SETTLE   = 3'd3,
        IR_REQ   = 3'd4,
        IR_WAIT  = 3'd5,
        RUN      = 3'd6,
        ERROR    = 3'd7
    } state_t;

    state_t      state;
    state_t      next_state;
    logic [16:0] count;
    logic [16:0] count_inc;
    logic        counting;

    // Limits are compared against the already-incremented count, so a limit of N
    // fires on the edge that samples the Nth strobe.
    always_comb begin
        counting  = (state == OFS_WAIT) || (state == SETTLE) || (state == IR_WAIT);
        count_inc = count;
        if (counting && audio_trigger && (count != 17'h1FFFF)) begin
            count_inc = count + 17'd1;
        end

        next_state = state;
        if (abort) begin
            next_state = IDLE;
        end else begin
            case (state)
                IDLE, RUN, ERROR: if (start) next_state = OFS_REQ;
                OFS_REQ:          next_state = OFS_WAIT;
                OFS_WAIT: begin
                    if (offset_done)                         next_state = SETTLE;
                    else if (count_inc >= OFFSET_TIMEOUT)    next_state = ERROR;
                end
                SETTLE:   if (count_inc >= SETTLE_SAMPLES)   next_state = IR_REQ;
                IR_REQ:           next_state = IR_WAIT;
                IR_WAIT: begin
                    if (impulse_done)                        next_state = RUN;
                    else if (count_inc >= IMPULSE_TIMEOUT)   next_state = ERROR;
                end
                default:          next_state = IDLE;
            endcase
        end
    end

    // Outputs are registered from the next state so they line up with the state register.
    always_ff @(posedge audio_clk or posedge rst_in) begin
        if (rst_in) begin
            state               <= IDLE;
            count               <= 17'd0;
            offset_trigger_out  <= 1'b0;
            impulse_trigger_out <= 1'b0;
            conv_enable         <= 1'b0;
            spk_mute            <= 1'b0;
            busy                <= 1'b0;
            error               <= 1'b0;
        end else begin
            state               <= next_state;
            count               <= (next_state != state) ? 17'd0 : count_inc;
            offset_trigger_out  <= (next_state == OFS_REQ);
            impulse_trigger_out <= (next_state == IR_REQ);
            conv_enable         <= (next_state == RUN);
            spk_mute            <= (next_state == OFS_REQ) || (next_state == OFS_WAIT) ||
                                   (next_state == SETTLE);
            busy                <= (next_state != IDLE) && (next_state != RUN) &&
                                   (next_state != ERROR);
            error               <= (next_state == ERROR);
        end
    end

    assign state_out = state;

endmodule

// File: tb/tb_calibration_sequencer.sv
// Directed bench for calibration_sequencer with short sample limits and a 16-cycle strobe.
module tb_calibration_sequencer;

    logic       audio_clk = 1'b0;
    logic       rst_in = 1'b0;
    logic       audio_trigger = 1'b0;
    logic       start = 1'b0;
    logic       abort = 1'b0;
    logic       offset_done = 1'b0;
    logic       impulse_done = 1'b0;
    logic       offset_trigger_out;
    logic       impulse_trigger_out;
    logic       conv_enable;
    logic       spk_mute;
    logic       busy;
    logic       error;
    logic [2:0] state_out;

    int tests = 0;
    int failures = 0;
    int ofs_pulses = 0;
    int ir_pulses = 0;

    // {offset_trig, impulse_trig, conv_enable, spk_mute, busy, error, state_out}
    localparam logic [8:0] S_IDLE     = 9'b000000_000;
    localparam logic [8:0] S_OFS_REQ  = 9'b100110_001;
    localparam logic [8:0] S_OFS_WAIT = 9'b000110_010;
    localparam logic [8:0] S_SETTLE   = 9'b000110_011;
    localparam logic [8:0] S_IR_REQ   = 9'b010010_100;
    localparam logic [8:0] S_IR_WAIT  = 9'b000010_101;
    localparam logic [8:0] S_RUN      = 9'b001000_110;
    localparam logic [8:0] S_ERROR    = 9'b000001_111;

    calibration_sequencer #(
        .SETTLE_SAMPLES (17'd4),
        .OFFSET_TIMEOUT (17'd8),
        .IMPULSE_TIMEOUT(17'd8)
    ) dut (
        .audio_clk          (audio_clk),
        .rst_in             (rst_in),
        .audio_trigger      (audio_trigger),
        .start              (start),
        .abort              (abort),
        .offset_done        (offset_done),
        .impulse_done       (impulse_done),
        .offset_trigger_out (offset_trigger_out),
        .impulse_trigger_out(impulse_trigger_out),
        .conv_enable        (conv_enable),
        .spk_mute           (spk_mute),
        .busy               (busy),
        .error              (error),
        .state_out          (state_out)
    );

    always #5 audio_clk = ~audio_clk;

    always @(negedge audio_clk) begin
        if (offset_trigger_out)  ofs_pulses <= ofs_pulses + 1;
        if (impulse_trigger_out) ir_pulses  <= ir_pulses + 1;
    end

    function automatic logic [8:0] outs();
        return {offset_trigger_out, impulse_trigger_out, conv_enable, spk_mute, busy, error, state_out};
    endfunction

    task automatic cycle();
        @(posedge audio_clk);
        #1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        cycle();
        start = 1'b0;
    endtask

    // One sample period: 15 quiet cycles, then the strobe cycle carrying any done pulses.
    task automatic audio_sample(input logic ofs_d, input logic ir_d);
        repeat (15) cycle();
        audio_trigger = 1'b1;
        offset_done   = ofs_d;
        impulse_done  = ir_d;
        cycle();
        audio_trigger = 1'b0;
        offset_done   = 1'b0;
        impulse_done  = 1'b0;
    endtask

    task automatic test_reset();
        #2 rst_in = 1'b1;
        #1;
        tests++; if (outs() !== S_IDLE) begin failures++; $display("[TB] FAIL reset_state: got %b want %b", outs(), S_IDLE); end
        start = 1'b1;
        cycle();
        start = 1'b0;
        tests++; if (outs() !== S_IDLE) begin failures++; $display("[TB] FAIL reset_holds: got %b want %b", outs(), S_IDLE); end
        rst_in = 1'b0;
        cycle();
        tests++; if (outs() !== S_IDLE) begin failures++; $display("[TB] FAIL idle_after_release: got %b want %b", outs(), S_IDLE); end
    endtask

    task automatic test_happy_path();
        pulse_start();
        tests++; if (outs() !== S_OFS_REQ) begin failures++; $display("[TB] FAIL happy_ofs_req: got %b want %b", outs(), S_OFS_REQ); end
        offset_done = 1'b1;
        cycle();
        offset_done = 1'b0;
        tests++; if (outs() !== S_OFS_WAIT) begin failures++; $display("[TB] FAIL stale_done_ignored: got %b want %b", outs(), S_OFS_WAIT); end
        audio_sample(1'b0, 1'b0);
        audio_sample(1'b0, 1'b0);
        tests++; if (outs() !== S_OFS_WAIT) begin failures++; $display("[TB] FAIL happy_ofs_wait: got %b want %b", outs(), S_OFS_WAIT); end
        audio_sample(1'b1, 1'b0);
        tests++; if (outs() !== S_SETTLE) begin failures++; $display("[TB] FAIL happy_settle: got %b want %b", outs(), S_SETTLE); end
        for (int i = 1; i <= 3; i++) begin
            audio_sample(1'b0, 1'b0);
            tests++; if (outs() !== S_SETTLE) begin failures++; $display("[TB] FAIL settle_sample_%0d: got %b want %b", i, outs(), S_SETTLE); end
        end
        audio_sample(1'b0, 1'b0);
        tests++; if (outs() !== S_IR_REQ) begin failures++; $display("[TB] FAIL happy_ir_req: got %b want %b", outs(), S_IR_REQ); end
        cycle();
        tests++; if (outs() !== S_IR_WAIT) begin failures++; $display("[TB] FAIL happy_ir_wait: got %b want %b", outs(), S_IR_WAIT); end
        repeat (4) audio_sample(1'b0, 1'b0);
        tests++; if (outs() !== S_IR_WAIT) begin failures++; $display("[TB] FAIL happy_ir_wait_4: got %b want %b", outs(), S_IR_WAIT); end
        audio_sample(1'b0, 1'b1);
        tests++; if (outs() !== S_RUN) begin failures++; $display("[TB] FAIL happy_run: got %b want %b", outs(), S_RUN); end
        tests++; if (ofs_pulses !== 1) begin failures++; $display("[TB] FAIL happy_ofs_pulses: got %0d want 1", ofs_pulses); end
        tests++; if (ir_pulses !== 1) begin failures++; $display("[TB] FAIL happy_ir_pulses: got %0d want 1", ir_pulses); end
    endtask

    task automatic test_restart();
        pulse_start();
        tests++; if (outs() !== S_OFS_REQ) begin failures++; $display("[TB] FAIL restart_from_run: got %b want %b", outs(), S_OFS_REQ); end
        cycle();
        tests++; if (ofs_pulses !== 2) begin failures++; $display("[TB] FAIL restart_ofs_pulses: got %0d want 2", ofs_pulses); end
        audio_sample(1'b1, 1'b0);
        audio_sample(1'b0, 1'b0);
        pulse_start();
        tests++; if (outs() !== S_SETTLE) begin failures++; $display("[TB] FAIL start_ignored_settle: got %b want %b", outs(), S_SETTLE); end
        audio_sample(1'b0, 1'b0);
        audio_sample(1'b0, 1'b0);
        tests++; if (outs() !== S_SETTLE) begin failures++; $display("[TB] FAIL settle_after_start: got %b want %b", outs(), S_SETTLE); end
        audio_sample(1'b0, 1'b0);
        tests++; if (outs() !== S_IR_REQ) begin failures++; $display("[TB] FAIL settle_len_kept: got %b want %b", outs(), S_IR_REQ); end
        cycle();
        audio_sample(1'b0, 1'b1);
        tests++; if (outs() !== S_RUN) begin failures++; $display("[TB] FAIL restart_run: got %b want %b", outs(), S_RUN); end
        tests++; if (ir_pulses !== 2) begin failures++; $display("[TB] FAIL restart_ir_pulses: got %0d want 2", ir_pulses); end
    endtask

    task automatic test_offset_timeout();
        pulse_start();
        cycle();
        repeat (7) audio_sample(1'b0, 1'b0);
        tests++; if (outs() !== S_OFS_WAIT) begin failures++; $display("[TB] FAIL ofs_wait_7: got %b want %b", outs(), S_OFS_WAIT); end
        audio_sample(1'b0, 1'b0);
        tests++; if (outs() !== S_ERROR) begin failures++; $display("[TB] FAIL ofs_timeout: got %b want %b", outs(), S_ERROR); end
        offset_done = 1'b1;
        cycle();
        offset_done = 1'b0;
        tests++; if (outs() !== S_ERROR) begin failures++; $display("[TB] FAIL error_holds: got %b want %b", outs(), S_ERROR); end
    endtask

    task automatic test_simultaneous();
        pulse_start();
        tests++; if (outs() !== S_OFS_REQ) begin failures++; $display("[TB] FAIL restart_from_error: got %b want %b", outs(), S_OFS_REQ); end
        cycle();
        repeat (7) audio_sample(1'b0, 1'b0);
        audio_sample(1'b1, 1'b0);
        tests++; if (outs() !== S_SETTLE) begin failures++; $display("[TB] FAIL done_beats_timeout: got %b want %b", outs(), S_SETTLE); end
    endtask

    task automatic test_abort();
        repeat (4) audio_sample(1'b0, 1'b0);
        cycle();
        audio_sample(1'b0, 1'b0);
        audio_sample(1'b0, 1'b0);
        tests++; if (outs() !== S_IR_WAIT) begin failures++; $display("[TB] FAIL abort_pre_ir_wait: got %b want %b", outs(), S_IR_WAIT); end
        abort = 1'b1;
        start = 1'b1;
        cycle();
        abort = 1'b0;
        start = 1'b0;
        tests++; if (outs() !== S_IDLE) begin failures++; $display("[TB] FAIL abort_over_start: got %b want %b", outs(), S_IDLE); end
        repeat (9) audio_sample(1'b1, 1'b1);
        tests++; if (outs() !== S_IDLE) begin failures++; $display("[TB] FAIL abort_stays_idle: got %b want %b", outs(), S_IDLE); end
        tests++; if (ofs_pulses !== 4) begin failures++; $display("[TB] FAIL abort_ofs_pulses: got %0d want 4", ofs_pulses); end
        tests++; if (ir_pulses !== 3) begin failures++; $display("[TB] FAIL abort_ir_pulses: got %0d want 3", ir_pulses); end
    endtask

    task automatic test_impulse_timeout();
        pulse_start();
        cycle();
        audio_sample(1'b1, 1'b0);
        repeat (4) audio_sample(1'b0, 1'b0);
        cycle();
        repeat (7) audio_sample(1'b0, 1'b0);
        tests++; if (outs() !== S_IR_WAIT) begin failures++; $display("[TB] FAIL ir_wait_7: got %b want %b", outs(), S_IR_WAIT); end
        audio_sample(1'b0, 1'b0);
        tests++; if (outs() !== S_ERROR) begin failures++; $display("[TB] FAIL ir_timeout: got %b want %b", outs(), S_ERROR); end
    endtask

    task automatic test_reset_midsequence();
        pulse_start();
        cycle();
        audio_sample(1'b0, 1'b0);
        tests++; if (outs() !== S_OFS_WAIT) begin failures++; $display("[TB] FAIL pre_reset_wait: got %b want %b", outs(), S_OFS_WAIT); end
        #2 rst_in = 1'b1;
        #1;
        tests++; if (outs() !== S_IDLE) begin failures++; $display("[TB] FAIL async_reset: got %b want %b", outs(), S_IDLE); end
        cycle();
        rst_in = 1'b0;
        audio_sample(1'b1, 1'b0);
        audio_sample(1'b0, 1'b1);
        tests++; if (outs() !== S_IDLE) begin failures++; $display("[TB] FAIL done_after_reset: got %b want %b", outs(), S_IDLE); end
        tests++; if (ofs_pulses !== 6) begin failures++; $display("[TB] FAIL reset_ofs_pulses: got %0d want 6", ofs_pulses); end
        tests++; if (ir_pulses !== 4) begin failures++; $display("[TB] FAIL reset_ir_pulses: got %0d want 4", ir_pulses); end
    endtask

    initial begin
        test_reset();
        test_happy_path();
        test_restart();
        test_offset_timeout();
        test_simultaneous();
        test_abort();
        test_impulse_timeout();
        test_reset_midsequence();
        $display("[TB] %0d tests run, %0d failed", tests, failures);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule

// File: doc/calibration_sequencer.md
CALIBRATION_SEQUENCER -- requirements
Module: calibration_sequencer

Interface
REQ-001 SHALL have parameter SETTLE_SAMPLES, default 17'd2400, the number of audio_trigger pulses to wait between offset capture and impulse recording.
REQ-002 SHALL have parameter OFFSET_TIMEOUT, default 17'd48000, the number of audio_trigger pulses allowed for offset_done before error.
REQ-003 SHALL have parameter IMPULSE_TIMEOUT, default 17'd72000, the number of audio_trigger pulses allowed for impulse_done before error.
REQ-004 SHALL have port audio_clk, input, 1 bit: the single clock (98.3 MHz), all logic on its rising edge.
REQ-005 SHALL have port rst_in, input, 1 bit: reset, asynchronous and active-high.
REQ-006 SHALL have port audio_trigger, input, 1 bit: one-cycle 24 kHz sample strobe.
REQ-007 SHALL have port start, input, 1 bit: one-cycle request to begin calibration.
REQ-008 SHALL have port abort, input, 1 bit: level; forces return to idle.
REQ-009 SHALL have ports offset_done and impulse_done, input, 1 bit each: completion pulses from the offset calculator and the impulse recorder.
REQ-010 SHALL have ports offset_trigger_out and impulse_trigger_out, output, 1 bit each: one-cycle start pulses to those units.
REQ-011 SHALL have port conv_enable, output, 1 bit: convolution output permitted.
REQ-012 SHALL have port spk_mute, output, 1 bit: speaker mute during quiet-room measurement.
REQ-013 SHALL have ports busy and error, output, 1 bit each, and state_out, output, 3 bits: current state code.

Function
REQ-014 SHALL implement states IDLE=0, OFS_REQ=1, OFS_WAIT=2, SETTLE=3, IR_REQ=4, IR_WAIT=5, RUN=6, ERROR=7; state_out SHALL equal the registered state.
REQ-015 SHALL move IDLE->OFS_REQ on start; in RUN or ERROR, start SHALL also restart at OFS_REQ; in states 1-5, start SHALL be ignored.
REQ-016 SHALL stay in OFS_REQ exactly one cycle with offset_trigger_out=1, then go to OFS_WAIT.
REQ-017 SHALL, in OFS_WAIT, go to SETTLE on offset_done, or to ERROR when the sample counter reaches OFFSET_TIMEOUT.
REQ-018 SHALL, in SETTLE, go to IR_REQ when the sample counter reaches SETTLE_SAMPLES.
REQ-019 SHALL stay in IR_REQ exactly one cycle with impulse_trigger_out=1, then go to IR_WAIT.
REQ-020 SHALL, in IR_WAIT, go to RUN on impulse_done, or to ERROR when the sample counter reaches IMPULSE_TIMEOUT.
REQ-021 SHALL hold RUN and ERROR until start or abort.
REQ-022 SHALL use one 17-bit sample counter that clears on every state change and increments on each audio_trigger while in OFS_WAIT, SETTLE or IR_WAIT.
REQ-023 SHALL evaluate a counter limit after the increment, so a transition occurs on the cycle after the Nth audio_trigger.
REQ-024 SHALL saturate the counter, never wrapping.
REQ-025 SHALL give a done pulse priority over a timeout in the same cycle.
REQ-026 SHALL ignore done pulses outside their own wait state, including stale done pulses in the REQ cycle.
REQ-027 SHALL drive outputs from registered state only (Moore); a registered-state output changes one cycle after its causing input.
REQ-028 SHALL decode outputs as:
- busy=1 in states 1-5.
- spk_mute=1 in OFS_REQ, OFS_WAIT and SETTLE.
- conv_enable=1 only in RUN.
- error=1 only in ERROR.
REQ-029 SHALL give abort highest priority: any state goes to IDLE next cycle, the counter clears, and abort overrides a simultaneous start.

Reset
REQ-030 SHALL, on rst_in high, asynchronously force state IDLE and counter 0, with all outputs 0.
REQ-031 SHALL, on rst_in mid-sequence, emit no trigger pulses and ignore done pulses until a new start after release.

Verification
REQ-032 SHALL be run with SETTLE_SAMPLES=4, OFFSET_TIMEOUT=8 and IMPULSE_TIMEOUT=8, with audio_trigger every 16 cycles, and SHALL cover:
- Happy path: start, then offset_done 3 samples later, then impulse_done 5 samples after the IR trigger -> exactly one offset_trigger_out pulse and one impulse_trigger_out pulse, spk_mute high through SETTLE, state_out=6, conv_enable=1.
- Offset timeout: start and no offset_done -> state ERROR (7) one cycle after the 8th audio_trigger, error=1, busy=0.
- Simultaneity: offset_done on the same cycle as the 8th audio_trigger in OFS_WAIT -> SETTLE, not ERROR.
- Abort: abort in IR_WAIT plus start in the same cycle -> IDLE, all outputs 0, and no further triggers.
- Restart: start during SETTLE -> ignored, and SETTLE still lasts 4 samples; then start in RUN -> conv_enable drops and offset_trigger_out pulses once.
- Reset: rst_in asserted asynchronously mid-OFS_WAIT -> outputs 0 immediately; a later offset_done has no effect.
